// File: rtl/sw_input_port.sv
// Switch input responder on the MIO bus: synchronises and debounces the switches,
// and keeps sticky rise/fall events, an event mask and a level-sensitive irq.
module sw_input_port #(
   parameter int N_SW     = 16,
   parameter int TICK_DIV = 100000,
   parameter int DB_TICKS = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_SW-1:0] sw_i,
   input  logic            cs,
   input  logic            we,
   input  logic [1:0]      addr,
   input  logic [31:0]     wdata,
   output logic [31:0]     rdata,
   output logic            rvalid,
   output logic            irq
);

   localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_DIV - 1);
   localparam logic [7:0]     DB_LAST   = 8'(DB_TICKS - 1);

   logic [N_SW-1:0] r_sync1, r_sync2, r_stable;
   logic [N_SW-1:0] r_rise, r_fall, r_mask_r, r_mask_f;
   logic [7:0]      r_cnt [N_SW];
   logic [PW-1:0]   r_presc;

   logic            w_tick;
   logic [N_SW-1:0] w_stable_nxt, w_rise_set, w_fall_set;
   logic [N_SW-1:0] w_rise_nxt, w_fall_nxt, w_mask_r_nxt, w_mask_f_nxt;
   logic [7:0]      w_cnt_nxt [N_SW];
   logic            w_wr_evt, w_wr_mask, w_rd;
   logic [31:0]     w_rsel;
   logic            w_unused;

   assign w_tick    = (r_presc == TICK_LAST);
   assign w_wr_evt  = cs & we & (addr == 2'd1);
   assign w_wr_mask = cs & we & (addr == 2'd3);
   assign w_rd      = cs & ~we;
   assign w_unused  = ^wdata;

   always_comb begin
      w_stable_nxt = r_stable;
      w_rise_set   = '0;
      w_fall_set   = '0;
      for (int i = 0; i < N_SW; i++) begin
         w_cnt_nxt[i] = r_cnt[i];
         if (w_tick) begin
            if (r_sync2[i] == r_stable[i]) begin
               w_cnt_nxt[i] = 8'd0;
            end else if (r_cnt[i] == DB_LAST) begin
               w_stable_nxt[i] = r_sync2[i];
               w_cnt_nxt[i]    = 8'd0;
               w_rise_set[i]   = r_sync2[i];
               w_fall_set[i]   = ~r_sync2[i];
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + 8'd1;
            end
         end
      end
   end

   // a new edge in the same cycle as its W1C keeps the bit set
   assign w_rise_nxt   = (r_rise & ~(w_wr_evt ? wdata[N_SW-1:0]    : '0)) | w_rise_set;
   assign w_fall_nxt   = (r_fall & ~(w_wr_evt ? wdata[16 +: N_SW]  : '0)) | w_fall_set;
   assign w_mask_r_nxt = w_wr_mask ? wdata[N_SW-1:0]   : r_mask_r;
   assign w_mask_f_nxt = w_wr_mask ? wdata[16 +: N_SW] : r_mask_f;

   always_comb begin
      w_rsel = 32'd0;
      case (addr)
         2'd0: w_rsel = 32'(r_stable);
         2'd1: w_rsel = {16'(r_fall), 16'(r_rise)};
         2'd2: w_rsel = 32'(r_sync2);
         2'd3: w_rsel = {16'(r_mask_f), 16'(r_mask_r)};
         default: w_rsel = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_stable <= '0;
         r_rise   <= '0;
         r_fall   <= '0;
         r_mask_r <= '0;
         r_mask_f <= '0;
         r_presc  <= '0;
         for (int i = 0; i < N_SW; i++) r_cnt[i] <= 8'd0;
         rdata    <= 32'd0;
         rvalid   <= 1'b0;
         irq      <= 1'b0;
      end else begin
         r_sync1  <= sw_i;
         r_sync2  <= r_sync1;
         r_stable <= w_stable_nxt;
         r_rise   <= w_rise_nxt;
         r_fall   <= w_fall_nxt;
         r_mask_r <= w_mask_r_nxt;
         r_mask_f <= w_mask_f_nxt;
         r_presc  <= w_tick ? '0 : r_presc + 1'b1;
         for (int i = 0; i < N_SW; i++) r_cnt[i] <= w_cnt_nxt[i];
         rvalid   <= w_rd;
         if (w_rd) rdata <= w_rsel;
         irq      <= (|(w_rise_nxt & w_mask_r_nxt)) | (|(w_fall_nxt & w_mask_f_nxt));
      end
   end

endmodule

// File: tb/tb_sw_input_port.sv
// Directed bench for sw_input_port with a fast prescaler (TICK_DIV=4, DB_TICKS=3, 8 switches).
module tb_sw_input_port;

   localparam int N_SW = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [N_SW-1:0] sw_i;
   logic            cs, we;
   logic [1:0]      addr;
   logic [31:0]     wdata;
   logic [31:0]     rdata;
   logic            rvalid, irq;

   int checks = 0;
   int errors = 0;
   int n_cyc  = 0;
   logic [31:0] v;

   sw_input_port #(.N_SW(N_SW), .TICK_DIV(4), .DB_TICKS(3)) dut (
      .clk(clk), .rst(rst), .sw_i(sw_i), .cs(cs), .we(we), .addr(addr),
      .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .irq(irq)
   );

   always #5 clk = ~clk;

   // cycles since reset release; a prescaler tick happens on the edge where n_cyc%4 == 3
   always @(posedge clk) begin
      if (rst) n_cyc <= 0;
      else     n_cyc <= n_cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      cs = 1'b1; we = 1'b0; addr = a;
      @(negedge clk);
      cs = 1'b0;
      check("rvalid_on_read", 32'(rvalid), 32'd1);
      d = rdata;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      cs = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      cs = 1'b0; we = 1'b0; wdata = 32'd0;
   endtask

   task automatic wait_phase();
      while (n_cyc % 4 != 0) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; sw_i = '0; cs = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'd0;

      // 1 reset
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset_rdata", rdata, 32'd0);
      check("reset_rvalid", 32'(rvalid), 32'd0);
      check("reset_irq", 32'(irq), 32'd0);
      rd(2'd0, v); check("reset_level", v, 32'h0);

      // 2 press bit0
      sw_i[0] = 1'b1;
      repeat (15) @(negedge clk);
      rd(2'd0, v); check("press_level", v, 32'h1);
      @(negedge clk);
      check("rdata_hold", rdata, 32'h1);
      check("rvalid_idle", 32'(rvalid), 32'd0);
      rd(2'd1, v); check("press_event", v, 32'h1);
      check("irq_unmasked", 32'(irq), 32'd0);
      wr(2'd3, 32'hFFFF_FFFF);
      rd(2'd3, v); check("mask_width", v, 32'h00FF_00FF);
      wr(2'd3, 32'h0000_0001);
      check("irq_masked", 32'(irq), 32'd1);
      wr(2'd0, 32'hFFFF_FFFF);
      wr(2'd2, 32'hFFFF_FFFF);
      rd(2'd0, v); check("level_wr_ignored", v, 32'h1);

      // 3 glitch on bit3
      sw_i[3] = 1'b1;
      repeat (6) @(negedge clk);
      sw_i[3] = 1'b0;
      repeat (20) @(negedge clk);
      rd(2'd0, v); check("glitch_level", v, 32'h1);
      rd(2'd1, v); check("glitch_event", v, 32'h1);
      check("glitch_irq", 32'(irq), 32'd1);

      // 4 release and W1C
      sw_i[0] = 1'b0;
      repeat (15) @(negedge clk);
      rd(2'd1, v); check("release_event", v, 32'h0001_0001);
      wr(2'd3, 32'h0001_0001);
      wr(2'd1, 32'h0000_0001);
      check("irq_fall_pending", 32'(irq), 32'd1);
      rd(2'd1, v); check("w1c_rise", v, 32'h0001_0000);
      wr(2'd1, 32'h0001_0000);
      check("irq_cleared", 32'(irq), 32'd0);
      rd(2'd1, v); check("w1c_fall", v, 32'h0);

      // 5 W1C collides with the accepting tick of a bit5 rise
      wait_phase();
      sw_i[5] = 1'b1;
      repeat (11) @(negedge clk);
      wr(2'd1, 32'h0000_0020);
      rd(2'd1, v); check("collision_set_wins", v, 32'h20);
      rd(2'd0, v); check("collision_level", v, 32'h20);
      wr(2'd1, 32'h0000_0020);
      rd(2'd1, v); check("collision_cleared", v, 32'h0);

      // 6 reset in the middle of a debounce
      wait_phase();
      sw_i = 8'h04;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst2_rvalid", 32'(rvalid), 32'd0);
      check("rst2_rdata", rdata, 32'd0);
      repeat (2) @(negedge clk);
      rd(2'd2, v); check("rst2_raw", v, 32'h04);
      repeat (8) @(negedge clk);
      rd(2'd0, v); check("rst2_level_pending", v, 32'h0);
      rd(2'd0, v); check("rst2_level", v, 32'h04);
      rd(2'd1, v); check("rst2_event", v, 32'h04);
      rd(2'd3, v); check("rst2_mask", v, 32'h0);
      check("rst2_irq", 32'(irq), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
